// File: rtl/pwm_breather.sv
`timescale 1ns/1ps
// ============================================================================
// pwm_breather
// ----------------------------------------------------------------------------
// Multi-channel PWM engine driven by an autonomous brightness sequencer.
// A prescaler produces step ticks. On each tick the sequencer moves a shared
// brightness level in one of three patterns: static, triangle ("breathe") or
// sawtooth. A free-running PWM counter compares that level against a
// per-channel phase-shifted count. This staggers the channel edges so they
// never switch together.
//
// Ports:
//   ICE_CLK       in   system clock
//   RST_N         in   synchronous active-low reset
//   enable        in   1 = sequencer steps, 0 = level frozen (PWM still runs)
//   mode          in   00 static, 01 triangle, 10 sawtooth, 11 static
//   step_div      in   level steps once every step_div+1 clocks
//   static_level  in   level used while in static mode
//   pwm_out       out  registered PWM outputs, one per channel
//   level         out  current sequencer level
//   dir_down      out  triangle direction (0 = rising, 1 = falling)
//   period_start  out  one-cycle pulse while the PWM counter is 0
// ============================================================================
module pwm_breather #(
    parameter int                     CHANNELS  = 4,
    parameter int                     PWM_WIDTH = 8,
    parameter int                     DIV_WIDTH = 16,
    parameter logic [CHANNELS-1:0]    INVERT    = '0
) (
    input  logic                      ICE_CLK,
    input  logic                      RST_N,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [DIV_WIDTH-1:0]      step_div,
    input  logic [PWM_WIDTH-1:0]      static_level,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [PWM_WIDTH-1:0]      level,
    output logic                      dir_down,
    output logic                      period_start
);

    typedef enum logic [1:0] {
        MODE_STATIC     = 2'b00,
        MODE_TRIANGLE   = 2'b01,
        MODE_SAWTOOTH   = 2'b10,
        MODE_STATIC_ALT = 2'b11
    } mode_e;

    localparam logic [PWM_WIDTH-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_WIDTH-1:0] LEVEL_ONE = PWM_WIDTH'(1);

    mode_e                  modeSel;
    logic                   stepTick;
    logic                   pwmWrap;

    logic [DIV_WIDTH-1:0]   divCnt_q,       divCnt_d;
    logic [PWM_WIDTH-1:0]   level_q,        level_d;
    logic                   dirDown_q,      dirDown_d;
    logic [PWM_WIDTH-1:0]   pwmCnt_q,       pwmCnt_d;
    logic [PWM_WIDTH-1:0]   activeLevel_q,  activeLevel_d;
    logic                   periodStart_q,  periodStart_d;
    logic [CHANNELS-1:0]    pwmOut_q,       pwmOut_d;

    assign modeSel = mode_e'(mode);

    // Prescaler: counts while enabled and ticks when it reaches step_div.
    // The compare is an exact equality. If step_div is lowered below the
    // current count, the counter runs on through its natural wrap before it
    // matches again.
    always_comb begin
        stepTick = 1'b0;
        divCnt_d = '0;
        if (enable) begin
            if (divCnt_q == step_div) begin
                stepTick = 1'b1;
                divCnt_d = '0;
            end else begin
                divCnt_d = divCnt_q + 1'b1;
            end
        end
    end

    // Level sequencer. Static mode tracks static_level every cycle regardless
    // of the tick. The triangle turns around at both ends, so MAX and 0 are
    // each shown for exactly one step per sweep.
    always_comb begin
        level_d   = level_q;
        dirDown_d = dirDown_q;
        case (modeSel)
            MODE_TRIANGLE: begin
                if (stepTick) begin
                    if (!dirDown_q) begin
                        if (level_q == LEVEL_MAX) begin
                            dirDown_d = 1'b1;
                            level_d   = LEVEL_MAX - 1'b1;
                        end else begin
                            level_d   = level_q + 1'b1;
                        end
                    end else begin
                        if (level_q == '0) begin
                            dirDown_d = 1'b0;
                            level_d   = LEVEL_ONE;
                        end else begin
                            level_d   = level_q - 1'b1;
                        end
                    end
                end
            end
            MODE_SAWTOOTH: begin
                if (stepTick) begin
                    dirDown_d = 1'b0;
                    level_d   = level_q + 1'b1;
                end
            end
            default: begin
                level_d = static_level;
            end
        endcase
    end

    // PWM timebase. The compare level is latched only on the last count of a
    // period. Every period therefore uses a single level, and a level change
    // never chops a pulse in half.
    always_comb begin
        pwmWrap       = (pwmCnt_q == LEVEL_MAX);
        pwmCnt_d      = pwmCnt_q + 1'b1;
        activeLevel_d = pwmWrap ? level_q : activeLevel_q;
        periodStart_d = pwmWrap;
    end

    // Each channel compares a phase-advanced copy of the counter. The phases
    // spread the channels evenly over one period.
    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        localparam logic [PWM_WIDTH-1:0] PHASE =
            PWM_WIDTH'((i * (2 ** PWM_WIDTH)) / CHANNELS);
        logic [PWM_WIDTH-1:0] cmpVal;
        assign cmpVal      = pwmCnt_q + PHASE;
        assign pwmOut_d[i] = (cmpVal < activeLevel_q) ^ INVERT[i];
    end

    // All state is held here. Reset is synchronous and overrides every other
    // input. The outputs return to their inactive (inversion-mask) levels.
    always_ff @(posedge ICE_CLK) begin
        if (!RST_N) begin
            divCnt_q      <= '0;
            level_q       <= '0;
            dirDown_q     <= 1'b0;
            pwmCnt_q      <= '0;
            activeLevel_q <= '0;
            periodStart_q <= 1'b0;
            pwmOut_q      <= INVERT;
        end else begin
            divCnt_q      <= divCnt_d;
            level_q       <= level_d;
            dirDown_q     <= dirDown_d;
            pwmCnt_q      <= pwmCnt_d;
            activeLevel_q <= activeLevel_d;
            periodStart_q <= periodStart_d;
            pwmOut_q      <= pwmOut_d;
        end
    end

    assign pwm_out      = pwmOut_q;
    assign level        = level_q;
    assign dir_down     = dirDown_q;
    assign period_start = periodStart_q;

endmodule

// File: tb/tb_pwm_breather.sv
`timescale 1ns/1ps
// ============================================================================
// tb_pwm_breather
// ----------------------------------------------------------------------------
// Self-checking bench for pwm_breather (4 channels, 8-bit PWM, 16-bit divider,
// inversion mask 4'b0101). Sequencer expectations are queued as each stimulus
// is applied. They are popped and compared on the falling edge that follows.
// PWM duty and phase are measured over whole periods.
// ============================================================================
module tb_pwm_breather;

    localparam int          CH  = 4;
    localparam logic [3:0]  INV = 4'b0101;

    logic        ICE_CLK;
    logic        RST_N;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] stepDiv;
    logic [7:0]  staticLevel;
    logic [3:0]  pwmOut;
    logic [7:0]  level;
    logic        dirDown;
    logic        periodStart;

    int          checks   = 0;
    int          failures = 0;
    logic [8:0]  expQ[$];
    int          activeCnt[CH];
    int          firstActive[CH];

    pwm_breather #(
        .CHANNELS  (CH),
        .PWM_WIDTH (8),
        .DIV_WIDTH (16),
        .INVERT    (INV)
    ) dut (
        .ICE_CLK      (ICE_CLK),
        .RST_N        (RST_N),
        .enable       (enable),
        .mode         (mode),
        .step_div     (stepDiv),
        .static_level (staticLevel),
        .pwm_out      (pwmOut),
        .level        (level),
        .dir_down     (dirDown),
        .period_start (periodStart)
    );

    // 100 MHz simulation clock; inputs change and outputs are sampled on the
    // falling edge, well away from the active edge.
    initial begin
        ICE_CLK = 1'b0;
        forever #5 ICE_CLK = ~ICE_CLK;
    end

    // Safety net in case a wait below somehow never returns.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] md,
                                 input logic [15:0] div, input logic [7:0] sl);
        enable      = en;
        mode        = md;
        stepDiv     = div;
        staticLevel = sl;
    endtask

    task automatic popAndCompare(input string tag);
        logic [8:0] e;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_level"}, int'(level), int'(e[7:0]));
            checkOutput({tag, "_dir"}, int'(dirDown), int'(e[8]));
        end
    endtask

    // Queue one expected (level, dir) pair, advance a clock, and compare.
    task automatic expectStep(input string tag, input int expLevel, input int expDir);
        logic [7:0] l;
        logic       d;
        l = expLevel[7:0];
        d = expDir[0];
        expQ.push_back({d, l});
        @(negedge ICE_CLK);
        popAndCompare(tag);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pwm_out"}, int'(pwmOut), int'(INV));
        checkOutput({tag, "_level"}, int'(level), 0);
        checkOutput({tag, "_dir"}, int'(dirDown), 0);
        checkOutput({tag, "_period_start"}, int'(periodStart), 0);
    endtask

    // Measures the next full PWM period. Sample j reflects counter value j.
    // When changeAt >= 0, static_level is rewritten mid-period to newLevel.
    task automatic measurePeriod(input int changeAt, input int newLevel);
        int guard;
        logic a;
        guard = 0;
        @(negedge ICE_CLK);
        while (!periodStart && guard < 600) begin
            @(negedge ICE_CLK);
            guard++;
        end
        if (!periodStart) checkOutput("period_start_timeout", 0, 1);
        for (int c = 0; c < CH; c++) begin
            activeCnt[c]   = 0;
            firstActive[c] = -1;
        end
        for (int j = 0; j < 256; j++) begin
            @(negedge ICE_CLK);
            for (int c = 0; c < CH; c++) begin
                a = pwmOut[c] ^ INV[c];
                if (a) begin
                    activeCnt[c]++;
                    if (firstActive[c] < 0) firstActive[c] = j;
                end
            end
            if (j == changeAt) staticLevel = newLevel[7:0];
        end
    endtask

    task automatic checkDuty(input string tag, input int expCount);
        for (int c = 0; c < CH; c++)
            checkOutput($sformatf("%s_ch%0d_count", tag, c), activeCnt[c], expCount);
    endtask

    initial begin
        int cnt;
        int expFirst[CH];
        expFirst = '{0, 192, 128, 64};

        // ---------------- Reset ----------------
        RST_N = 1'b0;
        applyStimulus(1'b0, 2'b00, 16'd0, 8'd0);
        repeat (3) @(negedge ICE_CLK);
        checkResetState("reset");
        RST_N = 1'b1;
        cnt = 0;
        do begin
            @(negedge ICE_CLK);
            cnt++;
        end while (!periodStart && cnt < 600);
        checkOutput("first_period_start_delay", cnt, 256);
        checkOutput("level0_outputs_inactive", int'(pwmOut), int'(INV));
        @(negedge ICE_CLK);
        checkOutput("period_start_one_cycle", int'(periodStart), 0);

        // ---------------- Static duty and phase ----------------
        staticLevel = 8'd64;
        @(negedge ICE_CLK);
        checkOutput("static_level_follow", int'(level), 64);
        measurePeriod(-1, 0);
        checkDuty("duty64", 64);
        for (int c = 0; c < CH; c++)
            checkOutput($sformatf("phase_ch%0d_first", c), firstActive[c], expFirst[c]);
        staticLevel = 8'd0;
        measurePeriod(-1, 0);
        checkDuty("duty0", 0);
        staticLevel = 8'd255;
        measurePeriod(-1, 0);
        checkDuty("duty255", 255);

        // ---------------- Glitch-free level update ----------------
        staticLevel = 8'd200;
        measurePeriod(49, 10);
        checkDuty("glitch_old", 200);
        measurePeriod(-1, 0);
        checkDuty("glitch_new", 10);

        // ---------------- Triangle from reset ----------------
        RST_N = 1'b0;
        applyStimulus(1'b1, 2'b01, 16'd0, 8'd0);
        repeat (3) @(negedge ICE_CLK);
        checkResetState("reset2");
        RST_N = 1'b1;
        for (int n = 1; n <= 520; n++) begin
            int p;
            int l;
            int d;
            logic [7:0] lb;
            logic       db;
            p  = n % 510;
            l  = (p <= 255) ? p : 510 - p;
            d  = (p > 255 || p == 0) ? 1 : 0;
            lb = l[7:0];
            db = d[0];
            expQ.push_back({db, lb});
        end
        for (int n = 1; n <= 520; n++) begin
            @(negedge ICE_CLK);
            popAndCompare("tri");
        end

        // ---------------- Rate and enable ----------------
        applyStimulus(1'b1, 2'b01, 16'd3, 8'd0);
        for (int k = 1; k <= 12; k++) expectStep("rate", 10 + k / 4, 0);
        applyStimulus(1'b0, 2'b01, 16'd3, 8'd0);
        for (int k = 1; k <= 10; k++) expectStep("hold", 13, 0);
        applyStimulus(1'b1, 2'b01, 16'd3, 8'd0);
        expectStep("reenable", 13, 0);
        expectStep("reenable", 13, 0);
        expectStep("reenable", 13, 0);
        expectStep("reenable", 14, 0);

        // ---------------- Sawtooth and mode switches ----------------
        applyStimulus(1'b0, 2'b00, 16'd0, 8'd254);
        expectStep("load254", 254, 0);
        applyStimulus(1'b1, 2'b10, 16'd0, 8'd254);
        expectStep("saw", 255, 0);
        expectStep("saw", 0, 0);
        expectStep("saw", 1, 0);
        applyStimulus(1'b0, 2'b00, 16'd0, 8'd255);
        expectStep("load255", 255, 0);
        applyStimulus(1'b1, 2'b01, 16'd0, 8'd255);
        expectStep("tri_top", 254, 1);
        applyStimulus(1'b0, 2'b00, 16'd0, 8'd100);
        expectStep("load100", 100, 1);
        applyStimulus(1'b1, 2'b01, 16'd0, 8'd100);
        expectStep("tri_resume", 99, 1);
        expectStep("tri_resume", 98, 1);
        applyStimulus(1'b0, 2'b00, 16'd0, 8'd0);
        expectStep("load0", 0, 1);
        applyStimulus(1'b1, 2'b01, 16'd0, 8'd0);
        expectStep("tri_bottom", 1, 0);
        expectStep("tri_bottom", 2, 0);
        applyStimulus(1'b0, 2'b00, 16'd0, 8'd255);
        expectStep("load255b", 255, 0);
        applyStimulus(1'b1, 2'b01, 16'd0, 8'd255);
        expectStep("tri_top2", 254, 1);
        applyStimulus(1'b1, 2'b10, 16'd0, 8'd255);
        expectStep("saw_dirclr", 255, 0);
        expectStep("saw_dirclr", 0, 0);
        applyStimulus(1'b1, 2'b01, 16'd0, 8'd0);
        expectStep("tri_ramp", 1, 0);
        expectStep("tri_ramp", 2, 0);

        // ---------------- Reset mid-ramp ----------------
        RST_N = 1'b0;
        @(negedge ICE_CLK);
        checkResetState("reset_mid");
        RST_N = 1'b1;
        @(negedge ICE_CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_breather.md
Name: pwm_breather

Overview:
Multi-channel PWM engine with an autonomous brightness ramp generator. It is the next generation of the single-channel fade/blink logic on the iCE board. The level sequencer steps a shared brightness level in one of three modes (static, triangle "breathe", sawtooth) at a programmable rate. Each channel drives a phase-staggered PWM output so channel edges do not coincide. Outputs drive LEDs or header pins directly.

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
PWM_WIDTH, 8, bits of PWM resolution; PWM period = 2^PWM_WIDTH clocks
DIV_WIDTH, 16, width of the step-rate divider
INVERT, {CHANNELS{1'b0}}, per-channel output inversion mask (bit i inverts pwm_out[i])

Ports:
ICE_CLK  input  1  system clock (12 MHz)
RST_N  input  1  synchronous active-low reset
enable  input  1  1 = sequencer runs; 0 = level frozen (PWM keeps running)
mode  input  2  00 static, 01 triangle, 10 sawtooth, 11 treated as static
step_div  input  DIV_WIDTH  level steps once every step_div+1 clocks
static_level  input  PWM_WIDTH  level used in static mode
pwm_out  output  CHANNELS  registered PWM outputs
level  output  PWM_WIDTH  current sequencer level (registered)
dir_down  output  1  triangle direction, 0 = up, 1 = down
period_start  output  1  one-cycle pulse when pwm_cnt wraps to 0

Behaviour:
- All state updates on posedge ICE_CLK. RST_N low at an edge forces: div_cnt=0, pwm_cnt=0, level=0, active_level=0, dir_down=0, period_start=0, pwm_out=INVERT. Reset mid-operation takes effect at the next edge regardless of other inputs.
- Prescaler: while enable=1, div_cnt increments. When div_cnt==step_div, step_tick=1 and div_cnt <= 0. step_div=0 gives a tick every cycle. While enable=0, div_cnt <= 0 and no ticks occur. A step_div change mid-count applies on the next compare; if div_cnt>step_div, div_cnt counts up, wraps at 2^DIV_WIDTH, then matches.
- Sequencer (updates only on step_tick; in static mode also see below):
  - static (00/11): level <= static_level every cycle, independent of enable and tick; dir_down unchanged.
  - triangle (01), up: level==MAX (2^PWM_WIDTH-1) -> dir_down<=1, level<=MAX-1; else level+1. Down: level==0 -> dir_down<=0, level<=1; else level-1. MAX and 0 are each held for exactly one step.
  - sawtooth (10): level <= level+1 modulo 2^PWM_WIDTH (MAX -> 0). dir_down forced to 0.
  - Mode changes take effect on the next edge. Triangle resumes from the current level and dir_down. If entered with dir_down=1 and level=0, the next step goes to 1.
- PWM counter: pwm_cnt (PWM_WIDTH bits) free-runs every cycle, wrapping MAX->0. Not gated by enable.
- Glitch-free update: active_level <= level only on the cycle pwm_cnt==MAX, so each PWM period uses one constant level.
- period_start is registered: 1 in the cycle after pwm_cnt==MAX (i.e., while pwm_cnt==0).
- Channel phase: phase_i = (i * 2^PWM_WIDTH / CHANNELS), truncated to PWM_WIDTH bits. cmp_i = (pwm_cnt + phase_i) mod 2^PWM_WIDTH.
- Output: pwm_out[i] <= ((cmp_i < active_level) XOR INVERT[i]). Latency is 1 clock from the counter value to the pin.
- Duty per channel = active_level / 2^PWM_WIDTH. Level 0 gives constant inactive. MAX gives high for 2^PWM_WIDTH-1 of every 2^PWM_WIDTH clocks; 100% duty is not supported.
- All arithmetic is unsigned modulo its register width. No combinational input-to-output paths.

Test Plan:
1. Reset: hold RST_N=0 for 3 clocks with INVERT=4'b0101 -> pwm_out=4'b0101, level=0, dir_down=0, period_start=0. First period_start occurs 256 clocks after release.
2. Static duty (PWM_WIDTH=8, CHANNELS=4): mode=00, static_level=64. Steady state: each channel high for exactly 64 of every 256 clocks. Channel rising edges are offset by 64 clocks (ch1 at +192 relative to ch0 due to the +phase advance, ch2 at +128, ch3 at +64). Set static_level=0 -> outputs constant low after the next wrap. Set 255 -> low for exactly 1 clock per period.
3. Triangle: mode=01, step_div=0, enable=1 from reset -> level goes 0,1,...,255, then dir_down=1, 254,...,0, then dir_down=0, 1. Period is 510 ticks; 255 and 0 each appear once per turn.
4. Rate and enable: step_div=3 -> level changes every 4 clocks. Drop enable for 10 clocks -> level and dir_down hold, PWM and period_start continue. Re-enable -> first step occurs 4 clocks later.
5. Sawtooth and mode switch: mode=10 from level=254 -> 255, 0, 1. Switch to mode=01 at level=100 with dir_down=1 -> next steps are 99, 98.
6. Glitch-free update: in static mode, change static_level from 200 to 10 while pwm_cnt=50 -> the current period still shows 200 high clocks; the next period shows 10. Assert RST_N=0 mid-ramp -> all reset values on the next edge.
